// File: rtl/mips_control.sv
// Moore FSM control unit for the multicycle MIPS datapath (lab ISA subset).
// Optional performance counters are built when MIPS_CTRL_PERF_EN is defined.
module mips_control #(
    parameter bit HALT_ON_ILLEGAL = 1'b1,
    parameter int PERF_W          = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    output logic              PCWrite,
    output logic              PCWriteCond,
    output logic              EQorNE,
    output logic              IorD,
    output logic              MemWrite,
    output logic              IRWrite,
    output logic [1:0]        RegDst,
    output logic [1:0]        MemtoReg,
    output logic              RegWrite,
    output logic              ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [2:0]        ALUOp,
    output logic [1:0]        PCSource,
    output logic              illegal_op,
    output logic [3:0]        state_out,
    output logic [PERF_W-1:0] perf_cycles,
    output logic [PERF_W-1:0] perf_instret
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_ITYPE_EX = 4'd8,
        S_ITYPE_WB = 4'd9,
        S_BR_CMP   = 4'd10,
        S_BR_TAKE  = 4'd11,
        S_JUMP     = 4'd12,
        S_JAL      = 4'd13,
        S_JR       = 4'd14,
        S_ILLEGAL  = 4'd15
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_RT  = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b110;

    state_t     r_state;
    state_t     w_state_next;
    logic       r_eq_ne;
    logic [2:0] r_itype_op;
    logic [2:0] w_itype_op;

    // Branch sense and immediate ALU op are captured when leaving DECODE so
    // that every output is a function of registered state only.
    always_comb begin
        w_itype_op = ALU_ADD;
        case (opcode)
            6'b001010: w_itype_op = ALU_SLT;
            6'b001100: w_itype_op = ALU_AND;
            6'b001101: w_itype_op = ALU_OR;
            6'b001110: w_itype_op = ALU_XOR;
            default:   w_itype_op = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_eq_ne    <= 1'b0;
            r_itype_op <= ALU_ADD;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_DECODE) begin
                r_eq_ne    <= (opcode == 6'b000100);
                r_itype_op <= w_itype_op;
            end
        end
    end

    always_comb begin
        w_state_next = S_FETCH;
        case (r_state)
            S_FETCH: w_state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    6'b000000: w_state_next = (funct == 6'b001000) ? S_JR : S_RTYPE_EX;
                    6'b100011,
                    6'b101011: w_state_next = S_MEM_ADDR;
                    6'b001000, 6'b001001, 6'b001010,
                    6'b001100, 6'b001101, 6'b001110: w_state_next = S_ITYPE_EX;
                    6'b000100,
                    6'b000101: w_state_next = S_BR_CMP;
                    6'b000010: w_state_next = S_JUMP;
                    6'b000011: w_state_next = S_JAL;
                    default:   w_state_next = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: w_state_next = (opcode == 6'b101011) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   w_state_next = S_MEM_WB;
            S_RTYPE_EX: w_state_next = S_RTYPE_WB;
            S_ITYPE_EX: w_state_next = S_ITYPE_WB;
            S_BR_CMP:   w_state_next = S_BR_TAKE;
            S_ILLEGAL:  w_state_next = HALT_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
            default:    w_state_next = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        EQorNE      = 1'b0;
        IorD        = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = ALU_ADD;
        PCSource    = 2'b00;
        illegal_op  = 1'b0;
        if (rst) begin
            // PC captures its reset vector; nothing else may write.
            PCWrite = 1'b1;
        end else begin
            case (r_state)
                S_FETCH: begin
                    IRWrite = 1'b1;
                    ALUSrcB = 2'b01;
                    PCWrite = 1'b1;
                end
                S_DECODE: ALUSrcB = 2'b11;
                S_MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEM_RD: IorD = 1'b1;
                S_MEM_WB: begin
                    MemtoReg = 2'b01;
                    RegWrite = 1'b1;
                end
                S_MEM_WR: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                end
                S_RTYPE_EX: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALU_RT;
                end
                S_RTYPE_WB: begin
                    RegDst   = 2'b01;
                    RegWrite = 1'b1;
                end
                S_ITYPE_EX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ALUOp   = r_itype_op;
                end
                S_ITYPE_WB: RegWrite = 1'b1;
                S_BR_CMP: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALU_SUB;
                    EQorNE  = r_eq_ne;
                end
                S_BR_TAKE: begin
                    ALUSrcB     = 2'b11;
                    PCWriteCond = 1'b1;
                    EQorNE      = r_eq_ne;
                end
                S_JUMP: begin
                    PCSource = 2'b10;
                    PCWrite  = 1'b1;
                end
                S_JAL: begin
                    RegDst   = 2'b10;
                    MemtoReg = 2'b10;
                    RegWrite = 1'b1;
                    PCSource = 2'b10;
                    PCWrite  = 1'b1;
                end
                S_JR: begin
                    PCSource = 2'b11;
                    PCWrite  = 1'b1;
                end
                S_ILLEGAL: illegal_op = 1'b1;
                default: ;
            endcase
        end
    end

    assign state_out = rst ? 4'd0 : r_state;

`ifdef MIPS_CTRL_PERF_EN
    localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

    logic [PERF_W-1:0] r_perf_cycles;
    logic [PERF_W-1:0] r_perf_instret;

    // An instruction retires on its return to FETCH; leaving ILLEGAL is not a retirement.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_cycles  <= '0;
            r_perf_instret <= '0;
        end else begin
            r_perf_cycles <= r_perf_cycles + PERF_ONE;
            if ((w_state_next == S_FETCH) && (r_state != S_ILLEGAL))
                r_perf_instret <= r_perf_instret + PERF_ONE;
        end
    end

    assign perf_cycles  = rst ? '0 : r_perf_cycles;
    assign perf_instret = rst ? '0 : r_perf_instret;
`else
    assign perf_cycles  = '0;
    assign perf_instret = '0;
`endif

endmodule
